phase_arbiter: RTL and testbench

PHASE_ARBITER -- requirements
Module: phase_arbiter

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 26 ++
 rtl/phase_arbiter.sv | 150 +++++++++++++++
 tb/tb_phase_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the phase arbiter: state encodings, approach
// indices, timer width and a one-hot helper.
package traffic_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_ALLRED = 3'd3,
    ST_EMERG  = 3'd4
  } phase_t;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // One-hot lamp pattern for an approach index
  function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
    logic [3:0] oh;
    oh = 4'b0000;
    case (dir)
      DIR_N: oh = 4'b0001;
      DIR_E: oh = 4'b0010;
      DIR_S: oh = 4'b0100;
      DIR_W: oh = 4'b1000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requesting approach found
// searching upward from ptr, wrapping modulo 4.
module rr_arbiter (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  logic [1:0] idx;

  // Walk from the farthest offset down to ptr so the nearest request wins
  always_comb begin
    winner = ptr;
    any    = 1'b0;
    idx    = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_arbiter.sv
// Four-approach traffic phase arbiter with round-robin service, min/max
// green timing, yellow and all-red clearance, and emergency preemption.
module phase_arbiter
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       emerg_req,
  input  logic [1:0] emerg_dir,
  output logic [3:0] grant,
  output logic [3:0] yellow,
  output logic [2:0] phase_state,
  output logic       phase_done
);

  if (MIN_GREEN < 1 || MIN_GREEN > 255 ||
      MAX_GREEN < MIN_GREEN || MAX_GREEN > 255 ||
      YELLOW_T < 1 || YELLOW_T > 255 ||
      ALLRED_T < 1 || ALLRED_T > 255) begin : g_param_check
    $fatal(1, "phase_arbiter: timing parameter out of range");
  end

  // Timer values on the last cycle of each timed interval
  localparam logic [TIMER_W-1:0] MIN_LAST = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAX_LAST = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YEL_LAST = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] RED_LAST = TIMER_W'(ALLRED_T - 1);

  phase_t             state_q, state_d;
  logic [1:0]         cur_q, cur_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         grant_d, yellow_d;
  logic               done_d;
  logic [1:0]         rr_winner;
  logic               rr_any;
  logic               others_req;
  logic               counting;

  rr_arbiter u_rr (
    .req    (req),
    .ptr    (ptr_q),
    .winner (rr_winner),
    .any    (rr_any)
  );

  assign others_req = |(req & ~dir_onehot(cur_q));
  assign counting   = (state_q == ST_GREEN) || (state_q == ST_YELLOW) ||
                      (state_q == ST_ALLRED);

  // State, indices, timer and registered lamp outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cur_q      <= DIR_N;
      ptr_q      <= DIR_N;
      timer_q    <= '0;
      grant      <= 4'b0000;
      yellow     <= 4'b0000;
      phase_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      grant      <= grant_d;
      yellow     <= yellow_d;
      phase_done <= done_d;
    end
  end

  // Next-state decisions; the timer saturates so an idle rest never wraps
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (emerg_req) begin
          state_d = ST_EMERG;
          cur_d   = emerg_dir;
        end else if (rr_any) begin
          state_d = ST_GREEN;
          cur_d   = rr_winner;
        end
      end
      ST_GREEN: begin
        if (emerg_req) begin
          ptr_d   = cur_q + 2'd1;
          state_d = (emerg_dir == cur_q) ? ST_EMERG : ST_YELLOW;
        end else if (others_req && (timer_q >= MIN_LAST) &&
                     (!req[cur_q] || (timer_q >= MAX_LAST))) begin
          ptr_d   = cur_q + 2'd1;
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (timer_q >= YEL_LAST) state_d = ST_ALLRED;
      end
      ST_ALLRED: begin
        if (timer_q >= RED_LAST) begin
          if (emerg_req) begin
            state_d = ST_EMERG;
            cur_d   = emerg_dir;
          end else if (rr_any) begin
            state_d = ST_GREEN;
            cur_d   = rr_winner;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_EMERG: begin
        if (!emerg_req || (emerg_dir != cur_q)) begin
          ptr_d   = cur_q + 2'd1;
          state_d = ST_YELLOW;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q)
      timer_d = '0;
    else if (counting && (timer_q != '1))
      timer_d = timer_q + 1'b1;
    else
      timer_d = timer_q;
  end

  // Lamp patterns for the upcoming state and the all-red exit pulse
  always_comb begin
    grant_d  = 4'b0000;
    yellow_d = 4'b0000;
    done_d   = (state_q == ST_ALLRED) && (timer_q >= RED_LAST);
    case (state_d)
      ST_GREEN, ST_EMERG: grant_d  = dir_onehot(cur_d);
      ST_YELLOW:          yellow_d = dir_onehot(cur_d);
      default: ;
    endcase
  end

  assign phase_state = state_q;

endmodule

// File: tb/tb_phase_arbiter.sv
// Directed testbench for phase_arbiter with default timing parameters.
module tb_phase_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       emerg_req;
  logic [1:0] emerg_dir;
  logic [3:0] grant;
  logic [3:0] yellow;
  logic [2:0] phase_state;
  logic       phase_done;

  int checks;
  int failures;
  int violations;

  phase_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .emerg_req   (emerg_req),
    .emerg_dir   (emerg_dir),
    .grant       (grant),
    .yellow      (yellow),
    .phase_state (phase_state),
    .phase_done  (phase_done)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lamp sanity watch: grant and yellow exclusive and each at most one-hot
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (((grant != 4'b0) && (yellow != 4'b0)) || !$onehot0(grant) || !$onehot0(yellow))
        violations++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq,
                               input logic em, input logic [1:0] dir);
    rst       = r;
    req       = rq;
    emerg_req = em;
    emerg_dir = dir;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0);
    tick();
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0);
    tick();
  endtask

  initial begin
    int bad;
    int g_ok, y_ok, r_ok, dn;
    logic [3:0] exp_g;
    checks     = 0;
    failures   = 0;
    violations = 0;

    // Reset and first grant latency
    applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0);
    tick();
    tick();
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_yellow", yellow, 0);
    checkOutput("rst_state", phase_state, 0);
    checkOutput("rst_done", phase_done, 0);
    applyStimulus(1'b1, 4'b0001, 1'b0, 2'd0);
    checkOutput("pre_edge_grant", grant, 0);
    tick();
    checkOutput("first_grant", grant, 4'b0001);
    checkOutput("first_state", phase_state, 1);

    // Lone request drops: rest on green
    applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0);
    bad = 0;
    repeat (200) begin
      tick();
      if ((grant !== 4'b0001) || (yellow !== 4'b0000)) bad++;
    end
    checkOutput("rest_bad_cycles", bad, 0);
    checkOutput("rest_state", phase_state, 1);

    // All approaches requesting: max-out rotation
    resetDut();
    applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0);
    for (int p = 0; p < 5; p++) begin
      exp_g = 4'b0001 << (p % 4);
      g_ok = 0; y_ok = 0; r_ok = 0; dn = 0;
      repeat (32) begin
        tick();
        if ((grant === exp_g) && (yellow === 4'b0) && (phase_state === 3'd1)) g_ok++;
        if (phase_done) dn++;
      end
      repeat (4) begin
        tick();
        if ((yellow === exp_g) && (grant === 4'b0) && (phase_state === 3'd2)) y_ok++;
        if (phase_done) dn++;
      end
      repeat (2) begin
        tick();
        if ((yellow === 4'b0) && (grant === 4'b0) && (phase_state === 3'd3)) r_ok++;
        if (phase_done) dn++;
      end
      checkOutput($sformatf("rot%0d_green", p), g_ok, 32);
      checkOutput($sformatf("rot%0d_yellow", p), y_ok, 4);
      checkOutput($sformatf("rot%0d_allred", p), r_ok, 2);
      checkOutput($sformatf("rot%0d_done", p), dn, (p == 0) ? 0 : 1);
    end

    // Gap-out at minimum green
    resetDut();
    applyStimulus(1'b1, 4'b0001, 1'b0, 2'd0);
    tick(); tick(); tick();
    checkOutput("gap_c3_grant", grant, 4'b0001);
    applyStimulus(1'b1, 4'b0010, 1'b0, 2'd0);
    repeat (5) tick();
    checkOutput("gap_c8_grant", grant, 4'b0001);
    tick();
    checkOutput("gap_yellow", yellow, 4'b0001);
    checkOutput("gap_yellow_grant", grant, 4'b0000);
    repeat (3) tick();
    checkOutput("gap_y4", yellow, 4'b0001);
    tick();
    checkOutput("gap_allred", phase_state, 3);
    tick();
    tick();
    checkOutput("gap_next_grant", grant, 4'b0010);
    checkOutput("gap_done", phase_done, 1);

    // Emergency to another approach during green
    resetDut();
    applyStimulus(1'b1, 4'b0001, 1'b0, 2'd0);
    tick(); tick();
    applyStimulus(1'b1, 4'b0001, 1'b1, 2'd2);
    tick();
    checkOutput("em_yellow", yellow, 4'b0001);
    checkOutput("em_yellow_state", phase_state, 2);
    repeat (3) tick();
    checkOutput("em_y4", yellow, 4'b0001);
    tick();
    checkOutput("em_allred1", phase_state, 3);
    tick();
    checkOutput("em_allred2", phase_state, 3);
    tick();
    checkOutput("em_state", phase_state, 4);
    checkOutput("em_grant", grant, 4'b0100);
    checkOutput("em_done", phase_done, 1);
    repeat (5) tick();
    checkOutput("em_hold", grant, 4'b0100);
    applyStimulus(1'b1, 4'b1001, 1'b0, 2'd2);
    tick();
    checkOutput("em_exit_yellow", yellow, 4'b0100);
    checkOutput("em_exit_state", phase_state, 2);
    repeat (5) tick();
    tick();
    checkOutput("em_ptr3_grant", grant, 4'b1000);

    // Emergency matching current green: no flicker
    resetDut();
    applyStimulus(1'b1, 4'b0100, 1'b0, 2'd0);
    tick();
    checkOutput("same_green", grant, 4'b0100);
    applyStimulus(1'b1, 4'b0100, 1'b1, 2'd2);
    tick();
    checkOutput("same_state", phase_state, 4);
    checkOutput("same_grant", grant, 4'b0100);

    // Emergency from idle beats a simultaneous request; direction change ends it
    resetDut();
    applyStimulus(1'b1, 4'b0001, 1'b1, 2'd3);
    tick();
    checkOutput("idle_em_state", phase_state, 4);
    checkOutput("idle_em_grant", grant, 4'b1000);
    applyStimulus(1'b1, 4'b0001, 1'b1, 2'd1);
    tick();
    checkOutput("dirchg_yellow", yellow, 4'b1000);
    checkOutput("dirchg_state", phase_state, 2);

    // Reset in the middle of yellow
    resetDut();
    applyStimulus(1'b1, 4'b0001, 1'b0, 2'd0);
    tick();
    applyStimulus(1'b1, 4'b0010, 1'b0, 2'd0);
    repeat (9) tick();
    checkOutput("mid_y2_yellow", yellow, 4'b0001);
    checkOutput("mid_y2_state", phase_state, 2);
    applyStimulus(1'b0, 4'b0010, 1'b0, 2'd0);
    tick();
    checkOutput("mid_rst_grant", grant, 0);
    checkOutput("mid_rst_yellow", yellow, 0);
    checkOutput("mid_rst_state", phase_state, 0);
    applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0);
    tick();
    checkOutput("post_rst_idle", phase_state, 0);

    checkOutput("lamp_violations", violations, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
